fetch_unit: RTL

//  Instruction fetch sequencer that consumes the program counter register's address output.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Drives the PC strobes, reads 1-3 bytes from memory per instruction,
// assembles them into the instruction register and hands the result to
// the decoder with a valid/ready handshake.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall_cnt
// output counting cycles where ir_valid=1 and ir_ready=0.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  flush,
    output logic                  pc_oe_a,
    output logic                  pc_cnt_en,
    output logic                  mem_cs,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] ir_opcode,
    output logic [DATA_WIDTH-1:0] ir_op1,
    output logic [DATA_WIDTH-1:0] ir_op2,
    output logic [1:0]            ir_len,
    output logic                  ir_valid,
    input  logic                  ir_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] LAT = MEM_LATENCY[2:0];

    state_t     state;
    logic [1:0] byte_idx;
    logic [2:0] wait_cnt;
    logic       byte_done;
    logic [1:0] len_dec;
    logic [1:0] len_now;
    logic       last_byte;

    // Strobe decode from the registered state; PC advance is suppressed by flush
    always_comb begin
        pc_oe_a   = (state == READ);
        mem_cs    = (state == READ);
        mem_oe    = (state == READ);
        byte_done = (state == READ) && (wait_cnt == LAT);
        pc_cnt_en = byte_done && !flush;
        unique case (mem_data[DATA_WIDTH-1 -: 2])
            2'b00:   len_dec = 2'd1;
            2'b01:   len_dec = 2'd2;
            default: len_dec = 2'd3;
        endcase
        // While byte 0 is arriving the length is known only from the bus
        len_now   = (byte_idx == 2'd0) ? len_dec : ir_len;
        last_byte = (byte_idx == (len_now - 2'd1));
    end

    // Fetch FSM: byte sequencing, IR assembly and decoder handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            ir_opcode <= '0;
            ir_op1    <= '0;
            ir_op2    <= '0;
            ir_len    <= '0;
            ir_valid  <= 1'b0;
        end else if (flush) begin
            ir_opcode <= '0;
            ir_op1    <= '0;
            ir_op2    <= '0;
            ir_len    <= '0;
            ir_valid  <= 1'b0;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            state     <= run ? READ : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state    <= READ;
                        byte_idx <= '0;
                        wait_cnt <= '0;
                    end
                end
                READ: begin
                    if (byte_done) begin
                        wait_cnt <= '0;
                        unique case (byte_idx)
                            2'd0: begin
                                ir_opcode <= mem_data;
                                ir_op1    <= '0;
                                ir_op2    <= '0;
                                ir_len    <= len_dec;
                            end
                            2'd1:    ir_op1 <= mem_data;
                            default: ir_op2 <= mem_data;
                        endcase
                        if (last_byte) begin
                            ir_valid <= 1'b1;
                            byte_idx <= '0;
                            state    <= HOLD;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        byte_idx <= '0;
                        wait_cnt <= '0;
                        state    <= run ? READ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles the decoder leaves a valid IR waiting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (flush) begin
            stall_cnt <= '0;
        end else if (ir_valid && !ir_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
